uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter half of the UART: accepts one byte per valid/ready handshake and shifts it out on `tx_o` as a standard asynchronous frame. The frame is start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Configuration fields and bit-period semantics match the UART receiver, so a TX/RX pair on one set of register fields interoperates directly. The block sits between the register/FIFO front end and the pad.

## Interface
- No parameters.
- `clk_i` input 1: system clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `cfg_en_i` input 1: transmitter enable; low forces idle.
- `cfg_div_i` input 16: bit period is `cfg_div_i + 1` clock cycles.
- `cfg_parity_en_i` input 1: append parity bit.
- `cfg_parity_sel_i` input 2: parity mode.
  - 00: odd, bit = ~^data.
  - 01: even, bit = ^data.
  - 10: space, bit = 0.
  - 11: mark, bit = 1.
- `cfg_bits_i` input 2: data bits; 00=5, 01=6, 10=7, 11=8.
- `cfg_stop_i` input 1: 0 = one stop bit, 1 = two stop bits.
- `tx_data_i` input 8: byte to send; only bits [N-1:0] are used.
- `tx_valid_i` input 1: `tx_data_i` is valid.
- `tx_ready_o` output 1: block can accept a byte.
- `tx_o` output 1: serial line; idles high.
- `busy_o` output 1: a frame is in progress.

## Operation
- FSM states: IDLE, START_BIT, DATA, PARITY, STOP_BIT.
- `tx_ready_o = cfg_en_i && (state == IDLE)`. This is combinational from state and enable only, not from `tx_valid_i`.
- Accept: `tx_valid_i && tx_ready_o` at a rising edge.
  - Latches `tx_data_i`, `cfg_div_i`, `cfg_bits_i`, `cfg_parity_en_i`, `cfg_parity_sel_i` and `cfg_stop_i` into shadow registers.
  - Enters START_BIT.
  - Configuration changes after acceptance do not affect the frame in progress.
- Parity is computed over the latched N data bits only.
- Baud counter:
  - Counts 0..div_q; a bit ends when the counter equals div_q.
  - The counter clears on every state entry.
  - `cfg_div_i = 0` gives 1 cycle per bit; this is legal.
- START_BIT: drive 0 for one bit period, then go to DATA with bit counter = 0.
- DATA: drive `shift_q[0]` for one bit period, then shift right.
  - After bit N-1, go to PARITY if parity is enabled, else STOP_BIT.
- PARITY: drive the parity bit for one bit period, then go to STOP_BIT.
- STOP_BIT: drive 1 for one bit period (two if `stop_q`), then go to IDLE.
- `busy_o = (state != IDLE)`.
- `cfg_en_i` low in any state:
  - Next edge: state = IDLE, `tx_o` = 1, counters = 0.
  - Any partial frame is abandoned and no handshake is lost.
  - While `cfg_en_i` is low, `tx_ready_o` = 0.
- Reset (`rst_i` high, asynchronous):
  - Outputs immediately: `tx_o` = 1, `busy_o` = 0, `tx_ready_o` = 0 while reset is held.
  - After reset release: `tx_ready_o` = `cfg_en_i`.
  - Internal state: FSM = IDLE, shift register = 0, counters = 0.
  - Reset mid-frame truncates the frame; the line returns high at once.

## Timing
- `tx_o` is a registered output, so there is no glitch path from the inputs.
- Latency: if accept happens at edge k, `tx_o` falls at edge k+1. The start bit occupies cycles k+1 .. k+1+div.
- Frame length: (1 + N + P + S) × (div+1) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- The state returns to IDLE at the edge that ends the last stop bit. `tx_ready_o` rises in that same cycle.
- Back-to-back: with `tx_valid_i` held high, the next byte is accepted on the first IDLE cycle. This leaves exactly 1 extra idle-high cycle between the end of the stop bit(s) and the next start bit.
- `tx_valid_i` with `tx_ready_o` low has no effect. The source must hold the data until accepted.

## Test plan
- 8N1, div=3, send 0x55:
  - Start bit 4 cycles low, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop 4 cycles high.
  - `tx_o` falls 1 cycle after accept.
  - `busy_o` is high for 40 cycles.
- 7 data bits, even parity, div=1, send 0xA3:
  - Data 1,1,0,0,0,1,0 (bit 7 dropped), parity bit = 1, one stop bit.
  - Frame = 20 cycles.
- 5 data bits, odd parity, 2 stop bits, div=0, send 0x1F:
  - 1,1,1,1,1, parity 0, two stop cycles high.
  - Frame = 9 cycles.
  - A loopback into `uart_rx` with the same config shows `err_o` = 0.
- Back-to-back 0x00 then 0xFF, 8N1, div=2, `tx_valid_i` held:
  - Second accept happens on the first IDLE cycle.
  - Exactly 1 high cycle separates the first stop bit from the second start bit.
  - Changing `cfg_bits_i` mid-frame does not alter the first frame.
- Deassert `cfg_en_i` during DATA:
  - Next cycle: `tx_o` = 1, `busy_o` = 0, `tx_ready_o` = 0.
  - After re-enable, `tx_ready_o` = 1 and the next frame is clean.
- Assert `rst_i` mid-PARITY:
  - `tx_o` = 1 and `busy_o` = 0 asynchronously, before the next clock edge.
  - After release, idle line and `tx_ready_o` = `cfg_en_i`.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter half of the UART.
// It accepts one byte per valid/ready handshake and sends it on tx_o as one
// asynchronous frame:
//   - a start bit (0),
//   - 5..8 data bits, LSB first,
//   - an optional parity bit,
//   - 1 or 2 stop bits (1).
// The data byte and the frame configuration are latched at accept. Config
// changes made mid-frame therefore do not affect the frame in progress.
// Ports:
//   clk_i, rst_i           clock, async active-high reset
//   cfg_en_i               transmitter enable (low forces idle)
//   cfg_div_i[15:0]        bit period = cfg_div_i + 1 clocks
//   cfg_parity_en_i        append parity bit
//   cfg_parity_sel_i[1:0]  00 odd, 01 even, 10 space, 11 mark
//   cfg_bits_i[1:0]        data bits 00=5 .. 11=8
//   cfg_stop_i             0 = one stop bit, 1 = two
//   tx_data_i[7:0]         byte to send
//   tx_valid_i/tx_ready_o  input handshake
//   tx_o                   serial line, idles high (registered)
//   busy_o                 frame in progress
module uart_tx (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_en_i,
   input  logic [15:0] cfg_div_i,
   input  logic        cfg_parity_en_i,
   input  logic [1:0]  cfg_parity_sel_i,
   input  logic [1:0]  cfg_bits_i,
   input  logic        cfg_stop_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic        tx_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, START_BIT, DATA, PARITY, STOP_BIT} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] div_q;
   logic [1:0]  bits_q;
   logic        par_en_q, stop_q, par_q;
   logic        tx_q, tx_d;
   logic        accept, bit_end;
   logic [7:0]  data_m;
   logic        par_calc;

   // The reset term keeps ready low while reset is held.
   assign tx_ready_o = cfg_en_i && (state_q == IDLE) && !rst_i;
   assign busy_o     = (state_q != IDLE);
   assign tx_o       = tx_q;
   assign accept     = tx_valid_i && tx_ready_o;
   assign bit_end    = (cnt_q == div_q);

   // Parity is taken over the N used data bits only. Unused upper bits are
   // masked off.
   assign data_m = tx_data_i & (8'hFF >> (2'd3 - cfg_bits_i));
   always_comb begin
      par_calc = 1'b0;
      case (cfg_parity_sel_i)
         2'b00: par_calc = ~^data_m;
         2'b01: par_calc = ^data_m;
         2'b10: par_calc = 1'b0;
         2'b11: par_calc = 1'b1;
         default: par_calc = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      bit_d      = bit_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               state_d = START_BIT;
               shift_d = tx_data_i;
            end
         end
         START_BIT: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               // {1, bits_q} is N-1, for N from 5 to 8.
               if (bit_q == {1'b1, bits_q}) begin
                  state_d    = par_en_q ? PARITY : STOP_BIT;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP_BIT;
               cnt_d      = '0;
               stop_cnt_d = 1'b0;
            end
         end
         STOP_BIT: begin
            if (bit_end) begin
               cnt_d = '0;
               if (stop_q && !stop_cnt_q) stop_cnt_d = 1'b1;
               else                       state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Disable abandons any partial frame on the next edge.
      if (!cfg_en_i) begin
         state_d    = IDLE;
         cnt_d      = '0;
         bit_d      = '0;
         stop_cnt_d = 1'b0;
      end
      // The line value is decoded from the next state, so tx_o comes
      // straight from a flop.
      case (state_d)
         START_BIT: tx_d = 1'b0;
         DATA:      tx_d = shift_d[0];
         PARITY:    tx_d = par_q;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         div_q      <= '0;
         bits_q     <= '0;
         par_en_q   <= 1'b0;
         stop_q     <= 1'b0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         if (accept) begin
            div_q    <= cfg_div_i;
            bits_q   <= cfg_bits_i;
            par_en_q <= cfg_parity_en_i;
            stop_q   <= cfg_stop_i;
            par_q    <= par_calc;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed testbench for uart_tx.
// Each test drives its own stimulus. Expected line waveforms come from
// hand-written frame bit lists, which are expanded by the bit period.
module tb_uart_tx;

   logic        clk, rst;
   logic        cfg_en;
   logic [15:0] cfg_div;
   logic        cfg_parity_en;
   logic [1:0]  cfg_parity_sel;
   logic [1:0]  cfg_bits;
   logic        cfg_stop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, tx, busy;

   int cmp_cnt = 0;
   int err_cnt = 0;

   uart_tx dut (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
      .cfg_parity_en_i(cfg_parity_en), .cfg_parity_sel_i(cfg_parity_sel),
      .cfg_bits_i(cfg_bits), .cfg_stop_i(cfg_stop), .tx_data_i(tx_data),
      .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_o(tx), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expand a frame bit list (sent order = bit 0 first) into per-cycle values.
   function automatic logic [63:0] expand(input logic [15:0] bits, input int nb, input int rep);
      logic [63:0] v = '0;
      for (int b = 0; b < nb; b++)
         for (int r = 0; r < rep; r++)
            v[b*rep + r] = bits[b];
      return v;
   endfunction

   // Record tx/busy for n cycles, starting in the cycle that follows accept.
   task automatic capture(input int n, output logic [63:0] line, output logic [63:0] bsy);
      line = '0;
      bsy  = '0;
      for (int i = 0; i < n; i++) begin
         line[i] = tx;
         bsy[i]  = busy;
         tick();
      end
   endtask

   task automatic config_frame(input logic [15:0] div, input logic pen, input logic [1:0] psel,
                               input logic [1:0] bits, input logic stop);
      cfg_div = div; cfg_parity_en = pen; cfg_parity_sel = psel;
      cfg_bits = bits; cfg_stop = stop;
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_en = 1'b1; tx_valid = 1'b0; tx_data = '0;
      config_frame(16'd3, 1'b0, 2'b00, 2'b11, 1'b0);
      #3;
      cmp_cnt++; if (tx !== 1'b1)       begin err_cnt++; $display("FAIL reset_tx got %b want 1", tx); end
      cmp_cnt++; if (busy !== 1'b0)     begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
      cmp_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready got %b want 0", tx_ready); end
      tick(); tick();
      rst = 1'b0;
      #1;
      cmp_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_release_ready got %b want 1", tx_ready); end
      tick();
   endtask

   task automatic test_8n1();
      logic [63:0] line, bsy;
      config_frame(16'd3, 1'b0, 2'b00, 2'b11, 1'b0);
      send(8'h55);
      cmp_cnt++; if (tx !== 1'b0) begin err_cnt++; $display("FAIL 8n1_start_latency got %b want 0", tx); end
      capture(40, line, bsy);
      cmp_cnt++; if (line !== expand(16'h02AA, 10, 4))
         begin err_cnt++; $display("FAIL 8n1_line got %h want %h", line, expand(16'h02AA, 10, 4)); end
      cmp_cnt++; if (bsy !== 64'h0000_00FF_FFFF_FFFF)
         begin err_cnt++; $display("FAIL 8n1_busy got %h want %h", bsy, 64'h0000_00FF_FFFF_FFFF); end
      cmp_cnt++; if ({tx, busy, tx_ready} !== 3'b101)
         begin err_cnt++; $display("FAIL 8n1_after got %b want 101", {tx, busy, tx_ready}); end
   endtask

   task automatic test_7e1();
      logic [63:0] line, bsy;
      config_frame(16'd1, 1'b1, 2'b01, 2'b10, 1'b0);
      send(8'hA3);
      capture(20, line, bsy);
      // Sent bits: 0, 1100010, parity 1, stop 1.
      cmp_cnt++; if (line !== expand(16'h0346, 10, 2))
         begin err_cnt++; $display("FAIL 7e1_line got %h want %h", line, expand(16'h0346, 10, 2)); end
      cmp_cnt++; if (bsy !== 64'h0000_0000_000F_FFFF)
         begin err_cnt++; $display("FAIL 7e1_busy got %h want %h", bsy, 64'h0000_0000_000F_FFFF); end
   endtask

   task automatic test_5o2();
      logic [63:0] line, bsy;
      config_frame(16'd0, 1'b1, 2'b00, 2'b00, 1'b1);
      send(8'h1F);
      capture(9, line, bsy);
      // Sent bits: 0, 11111, parity 0, stop 1, stop 1.
      cmp_cnt++; if (line !== 64'h1BE) begin err_cnt++; $display("FAIL 5o2_line got %h want %h", line, 64'h1BE); end
      cmp_cnt++; if (bsy !== 64'h1FF)  begin err_cnt++; $display("FAIL 5o2_busy got %h want %h", bsy, 64'h1FF); end
      cmp_cnt++; if ({tx, busy} !== 2'b10) begin err_cnt++; $display("FAIL 5o2_after got %b want 10", {tx, busy}); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] line, exp_line;
      logic        rdy_gap, bsy_gap;
      config_frame(16'd2, 1'b0, 2'b00, 2'b11, 1'b0);
      tx_data = 8'h00; tx_valid = 1'b1;
      tick();
      tx_data = 8'hFF;
      line = '0; rdy_gap = 1'b0; bsy_gap = 1'b1;
      for (int i = 0; i < 61; i++) begin
         line[i] = tx;
         if (i == 30) begin rdy_gap = tx_ready; bsy_gap = busy; end
         if (i == 5)  cfg_bits = 2'b00;
         if (i == 20) cfg_bits = 2'b11;
         if (i == 31) tx_valid = 1'b0;
         tick();
      end
      exp_line = expand(16'h0200, 10, 3) | (64'd1 << 30) | (expand(16'h03FE, 10, 3) << 31);
      cmp_cnt++; if (line !== exp_line) begin err_cnt++; $display("FAIL b2b_line got %h want %h", line, exp_line); end
      cmp_cnt++; if (rdy_gap !== 1'b1) begin err_cnt++; $display("FAIL b2b_gap_ready got %b want 1", rdy_gap); end
      cmp_cnt++; if (bsy_gap !== 1'b0) begin err_cnt++; $display("FAIL b2b_gap_busy got %b want 0", bsy_gap); end
      tick();
   endtask

   task automatic test_disable();
      logic [63:0] line, bsy;
      config_frame(16'd3, 1'b0, 2'b00, 2'b11, 1'b0);
      send(8'hF0);
      repeat (6) tick();
      cmp_cnt++; if (tx !== 1'b0) begin err_cnt++; $display("FAIL dis_mid_data got %b want 0", tx); end
      cfg_en = 1'b0;
      tick();
      cmp_cnt++; if ({tx, busy, tx_ready} !== 3'b100)
         begin err_cnt++; $display("FAIL dis_abort got %b want 100", {tx, busy, tx_ready}); end
      // A valid request while disabled must be ignored.
      tx_data = 8'h00; tx_valid = 1'b1;
      repeat (3) tick();
      cmp_cnt++; if ({tx, busy} !== 2'b10)
         begin err_cnt++; $display("FAIL dis_valid_ignored got %b want 10", {tx, busy}); end
      tx_valid = 1'b0;
      cfg_en = 1'b1;
      #1;
      cmp_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL dis_reenable_ready got %b want 1", tx_ready); end
      tick();
      send(8'h55);
      capture(40, line, bsy);
      cmp_cnt++; if (line !== expand(16'h02AA, 10, 4))
         begin err_cnt++; $display("FAIL dis_clean_frame got %h want %h", line, expand(16'h02AA, 10, 4)); end
   endtask

   task automatic test_reset_parity();
      // 7O1, div=1, data 0xA3: the parity bit is 0, in cycles 16..17.
      config_frame(16'd1, 1'b1, 2'b00, 2'b10, 1'b0);
      send(8'hA3);
      repeat (16) tick();
      cmp_cnt++; if (tx !== 1'b0) begin err_cnt++; $display("FAIL rstpar_parity got %b want 0", tx); end
      rst = 1'b1;
      #2;
      cmp_cnt++; if ({tx, busy, tx_ready} !== 3'b100)
         begin err_cnt++; $display("FAIL rstpar_async got %b want 100", {tx, busy, tx_ready}); end
      tick();
      rst = 1'b0;
      #1;
      cmp_cnt++; if (tx_ready !== 1'b1) begin err_cnt++; $display("FAIL rstpar_ready got %b want 1", tx_ready); end
      repeat (3) tick();
      cmp_cnt++; if ({tx, busy} !== 2'b10) begin err_cnt++; $display("FAIL rstpar_idle got %b want 10", {tx, busy}); end
      cfg_en = 1'b0;
      #1;
      cmp_cnt++; if (tx_ready !== 1'b0) begin err_cnt++; $display("FAIL rstpar_ready_en0 got %b want 0", tx_ready); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_7e1();
      test_5o2();
      test_back_to_back();
      test_disable();
      test_reset_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
